// File: rtl/multdiv_pkg.sv
// multdiv_pkg
//   Shared encodings for the multiply/divide sequencer.
//   Op encodings, FSM state encoding and the default iteration count.
package multdiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_step_counter.sv
// multdiv_step_counter
//   Loadable down-counter that paces the RUN phase of the sequencer.
//   It stops at zero rather than wrapping.
// Ports:
//   Clk       in   clock, rising edge
//   Reset_n   in   asynchronous active-low reset (count cleared to 0)
//   load      in   load load_val (has priority over dec)
//   load_val  in   CNT_W value to load
//   dec       in   decrement enable
//   eq1       out  count == 1, meaning this is the last step cycle
module multdiv_step_counter
  import multdiv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             eq1
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count stops at zero so it cannot wrap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign eq1 = (count == CNT_W'(1));

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// multdiv_seq_ctrl
//   Sequencer for the iterative Booth multiply / restoring divide unit.
//   It latches the operands, clears the unit and then steps it for
//   ITER_CYCLES cycles. At the end it captures the unit's Hi/Lo result
//   into the architectural registers. It stalls the CPU through Busy,
//   flags divide-by-zero and applies MTHI/MTLO writes.
//   Optional feature macro: MULTDIV_EARLY_OUT_EN. When it is defined,
//   a MULT with a zero operand writes Hi = Lo = 0 without running the unit.
// Ports:
//   Clk, Reset_n         clock (rising edge), asynchronous active-low reset
//   Start, Op            begin operation (sampled in IDLE); 0 = MULT, 1 = DIV
//   RegA, RegB           multiplicand/dividend, multiplier/divisor
//   Abort                flush: cancels any in-flight operation
//   Hi_wr, Lo_wr         MTHI / MTLO write enables
//   Wr_data              MTHI / MTLO data
//   Busy                 high whenever the FSM is not idle
//   Done                 one-cycle pulse; Hi/Lo are already updated in that cycle
//   Div0                 one-cycle pulse for DIV with RegB == 0
//   Hi, Lo               architectural Hi/Lo registers
//   Unit_Clr             unit clear, high during LOAD
//   Unit_Step            unit iteration enable, high during RUN
//   Unit_Op              latched operation type
//   Unit_A, Unit_B       latched operands
//   Unit_Hi, Unit_Lo     unit result
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ITER_CYCLES = ITER_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Op,
  input  logic [DATA_W-1:0] RegA,
  input  logic [DATA_W-1:0] RegB,
  input  logic              Abort,
  input  logic              Hi_wr,
  input  logic              Lo_wr,
  input  logic [DATA_W-1:0] Wr_data,
  output logic              Busy,
  output logic              Done,
  output logic              Div0,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              Unit_Clr,
  output logic              Unit_Op,
  output logic              Unit_Step,
  output logic [DATA_W-1:0] Unit_A,
  output logic [DATA_W-1:0] Unit_B,
  input  logic [DATA_W-1:0] Unit_Hi,
  input  logic [DATA_W-1:0] Unit_Lo
);

  state_t state;
  logic   cnt_eq1;
`ifdef MULTDIV_EARLY_OUT_EN
  logic   early_pend;
`endif

  // The counter is loaded in LOAD and counts down through RUN.
  // RUN ends on the cycle in which the counter reads 1.
  multdiv_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (state == LOAD),
    .load_val (CNT_W'(ITER_CYCLES)),
    .dec      (state == RUN),
    .eq1      (cnt_eq1)
  );

  assign Busy      = (state != IDLE);
  assign Unit_Clr  = (state == LOAD);
  assign Unit_Step = (state == RUN);

  // Sequencer FSM together with the Hi/Lo registers and status pulses.
  // The MTHI/MTLO writes are applied first. A capture or early-out in the
  // same cycle overrides them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      Hi      <= '0;
      Lo      <= '0;
      Unit_A  <= '0;
      Unit_B  <= '0;
      Unit_Op <= OP_MULT;
      Done    <= 1'b0;
      Div0    <= 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
      early_pend <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      Div0 <= 1'b0;
      if (Hi_wr) Hi <= Wr_data;
      if (Lo_wr) Lo <= Wr_data;
`ifdef MULTDIV_EARLY_OUT_EN
      early_pend <= 1'b0;
      if (early_pend) Done <= 1'b1;
`endif
      if (Abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (Start) begin
              if ((Op == OP_DIV) && (RegB == '0)) begin
                Div0 <= 1'b1;
                Done <= 1'b1;
`ifdef MULTDIV_EARLY_OUT_EN
              end else if ((Op == OP_MULT) && ((RegA == '0) || (RegB == '0))) begin
                Hi         <= '0;
                Lo         <= '0;
                early_pend <= 1'b1;
`endif
              end else begin
                state   <= LOAD;
                Unit_Op <= Op;
                Unit_A  <= RegA;
                Unit_B  <= RegB;
              end
            end
          end
          LOAD: state <= RUN;
          RUN: begin
            if (cnt_eq1) state <= CAPTURE;
          end
          CAPTURE: begin
            Hi    <= Unit_Hi;
            Lo    <= Unit_Lo;
            Done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// tb_multdiv_seq_ctrl
//   Directed testbench for multdiv_seq_ctrl. It includes a model unit that
//   produces a valid result only after exactly 32 steps following a clear.
module tb_multdiv_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Op = 1'b0;
  logic [31:0] RegA = '0;
  logic [31:0] RegB = '0;
  logic        Abort = 1'b0;
  logic        Hi_wr = 1'b0;
  logic        Lo_wr = 1'b0;
  logic [31:0] Wr_data = '0;
  logic        Busy, Done, Div0, Unit_Clr, Unit_Op, Unit_Step;
  logic [31:0] Hi, Lo, Unit_A, Unit_B;
  logic [31:0] Unit_Hi, Unit_Lo;

  int checks = 0;
  int failures = 0;
  int step_cnt = 0;
  int m_steps = 0;
  logic [63:0] m_prod;

  multdiv_seq_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .RegA(RegA), .RegB(RegB),
    .Abort(Abort), .Hi_wr(Hi_wr), .Lo_wr(Lo_wr), .Wr_data(Wr_data),
    .Busy(Busy), .Done(Done), .Div0(Div0), .Hi(Hi), .Lo(Lo),
    .Unit_Clr(Unit_Clr), .Unit_Op(Unit_Op), .Unit_Step(Unit_Step),
    .Unit_A(Unit_A), .Unit_B(Unit_B), .Unit_Hi(Unit_Hi), .Unit_Lo(Unit_Lo)
  );

  always #5 Clk = ~Clk;

  // Model unit: tracks the steps taken since the last clear and shows the
  // result only once exactly 32 steps have been taken.
  always @(posedge Clk) begin
    if (Unit_Clr) m_steps <= 0;
    else if (Unit_Step) m_steps <= m_steps + 1;
  end

  always_comb begin
    m_prod  = {32'd0, Unit_A} * {32'd0, Unit_B};
    Unit_Hi = 32'hFFFF_FFFF;
    Unit_Lo = 32'hFFFF_FFFF;
    if (m_steps == 32) begin
      if (Unit_Op == 1'b0) begin
        Unit_Hi = m_prod[63:32];
        Unit_Lo = m_prod[31:0];
      end else if (Unit_B != 32'd0) begin
        Unit_Hi = Unit_A % Unit_B;
        Unit_Lo = Unit_A / Unit_B;
      end
    end
  end

  // Count the cycles in which Unit_Step is high, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Unit_Step) step_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "[TB] watchdog");
  end

  // Starts one operation at the current negedge and observes max_c cycles.
  // hiwr_c and restart_c optionally inject an MTHI write or a second Start
  // in the given cycle.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int max_c, input int hiwr_c, input int restart_c,
                       output int done_c, output int div0_c, output int done_n,
                       output int busy_first, output int busy_last, output int clr_n);
    done_c = 0; div0_c = 0; done_n = 0; busy_first = 0; busy_last = 0; clr_n = 0;
    step_cnt = 0;
    Start = 1'b1; Op = op; RegA = a; RegB = b;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge Clk);
      Start = (c == restart_c);
      if (c == restart_c) begin
        Op = 1'b1; RegA = 32'd100; RegB = 32'd7;
      end
      Hi_wr = (c == hiwr_c);
      Wr_data = 32'hDEAD_BEEF;
      if (Done) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (Div0 && div0_c == 0) div0_c = c;
      if (Busy) begin
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (Unit_Clr) clr_n++;
    end
    Start = 1'b0;
    Hi_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({Busy, Done, Div0, Unit_Clr, Unit_Op, Unit_Step} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {Busy, Done, Div0, Unit_Clr, Unit_Op, Unit_Step});
    end
    checks++;
    if ({Hi, Lo, Unit_A, Unit_B} !== 128'd0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 0", {Hi, Lo, Unit_A, Unit_B});
    end
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_mult();
    int dc, d0, dn, bf, bl, cn;
    do_op(1'b0, 32'd6, 32'd7, 40, 0, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 35) begin failures++; $display("[TB] FAIL mult_done_cycle: got %0d expected 35", dc); end
    checks++;
    if (dn !== 1) begin failures++; $display("[TB] FAIL mult_done_count: got %0d expected 1", dn); end
    checks++;
    if (step_cnt !== 32) begin failures++; $display("[TB] FAIL mult_steps: got %0d expected 32", step_cnt); end
    checks++;
    if (cn !== 1) begin failures++; $display("[TB] FAIL mult_clr: got %0d expected 1", cn); end
    checks++;
    if (Hi !== 32'd0 || Lo !== 32'd42) begin
      failures++; $display("[TB] FAIL mult_result: got %h_%h expected 0_2a", Hi, Lo);
    end
  endtask

  task automatic test_div();
    int dc, d0, dn, bf, bl, cn;
    do_op(1'b1, 32'd100, 32'd7, 40, 0, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 35) begin failures++; $display("[TB] FAIL div_done_cycle: got %0d expected 35", dc); end
    checks++;
    if (bf !== 1 || bl !== 34) begin
      failures++; $display("[TB] FAIL div_busy_window: got %0d..%0d expected 1..34", bf, bl);
    end
    checks++;
    if (Hi !== 32'd2 || Lo !== 32'd14) begin
      failures++; $display("[TB] FAIL div_result: got %0d/%0d expected 2/14", Hi, Lo);
    end
    checks++;
    if (d0 !== 0) begin failures++; $display("[TB] FAIL div_no_div0: got %0d expected 0", d0); end
  endtask

  task automatic test_div0();
    int dc, d0, dn, bf, bl, cn;
    do_op(1'b1, 32'd5, 32'd0, 4, 0, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (d0 !== 1 || dc !== 1) begin
      failures++; $display("[TB] FAIL div0_pulse: got div0@%0d done@%0d expected 1/1", d0, dc);
    end
    checks++;
    if (dn !== 1) begin failures++; $display("[TB] FAIL div0_done_count: got %0d expected 1", dn); end
    checks++;
    if (bf !== 0) begin failures++; $display("[TB] FAIL div0_busy: got first busy %0d expected none", bf); end
    checks++;
    if (Hi !== 32'd2 || Lo !== 32'd14) begin
      failures++; $display("[TB] FAIL div0_hilo: got %0d/%0d expected 2/14", Hi, Lo);
    end
  endtask

  task automatic test_abort();
    int dc, d0, dn, bf, bl, cn;
    int done_seen;
    done_seen = 0;
    Start = 1'b1; Op = 1'b0; RegA = 32'd3; RegB = 32'd5;
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) done_seen++;
      if (c == 10) begin
        checks++;
        if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before: got %b expected 1", Busy); end
        Abort = 1'b1;
      end
      if (c == 11) begin
        checks++;
        if (Busy !== 1'b0 || Unit_Step !== 1'b0) begin
          failures++; $display("[TB] FAIL abort_idle: got busy=%b step=%b expected 0/0", Busy, Unit_Step);
        end
        Abort = 1'b0;
      end
    end
    @(negedge Clk);
    if (Done) done_seen++;
    checks++;
    if (done_seen !== 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_seen); end
    checks++;
    if (Hi !== 32'd2 || Lo !== 32'd14) begin
      failures++; $display("[TB] FAIL abort_hilo: got %0d/%0d expected 2/14", Hi, Lo);
    end
    do_op(1'b0, 32'd9, 32'd9, 40, 0, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 35 || Lo !== 32'd81) begin
      failures++; $display("[TB] FAIL abort_restart: got done@%0d lo=%0d expected 35/81", dc, Lo);
    end
    // A Start that arrives together with Abort in IDLE must be dropped.
    Start = 1'b1; Abort = 1'b1; Op = 1'b1; RegA = 32'd1; RegB = 32'd0;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Div0 !== 1'b0) begin
      failures++; $display("[TB] FAIL abort_start_idle: got busy=%b done=%b div0=%b expected 0", Busy, Done, Div0);
    end
  endtask

  task automatic test_hi_write();
    int dc, d0, dn, bf, bl, cn;
    do_op(1'b0, 32'h0001_0000, 32'h0003_0000, 40, 34, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 35 || Hi !== 32'd3 || Lo !== 32'd0) begin
      failures++; $display("[TB] FAIL hiwr_capture: got done@%0d %h_%h expected 35 3_0", dc, Hi, Lo);
    end
    Hi_wr = 1'b1; Lo_wr = 1'b1; Wr_data = 32'hDEAD_BEEF;
    @(negedge Clk);
    Hi_wr = 1'b0; Lo_wr = 1'b0;
    checks++;
    if (Hi !== 32'hDEAD_BEEF || Lo !== 32'hDEAD_BEEF) begin
      failures++; $display("[TB] FAIL hiwr_idle: got %h_%h expected deadbeef_deadbeef", Hi, Lo);
    end
  endtask

  task automatic test_back_to_back();
    int dc, d0, dn, bf, bl, cn;
    do_op(1'b0, 32'd2, 32'd3, 40, 0, 5, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 35 || dn !== 1) begin
      failures++; $display("[TB] FAIL busy_start_done: got done@%0d count=%0d expected 35/1", dc, dn);
    end
    checks++;
    if (bl !== 34) begin failures++; $display("[TB] FAIL busy_start_queued: got last busy %0d expected 34", bl); end
    checks++;
    if (Hi !== 32'd0 || Lo !== 32'd6) begin
      failures++; $display("[TB] FAIL busy_start_result: got %0d/%0d expected 0/6", Hi, Lo);
    end
  endtask

  task automatic test_early_out();
    int dc, d0, dn, bf, bl, cn;
`ifdef MULTDIV_EARLY_OUT_EN
    do_op(1'b0, 32'd5, 32'd0, 6, 0, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 2 || bf !== 0 || cn !== 0) begin
      failures++; $display("[TB] FAIL early_out_timing: got done@%0d busy@%0d clr=%0d expected 2/0/0", dc, bf, cn);
    end
`else
    do_op(1'b0, 32'd5, 32'd0, 40, 0, 0, dc, d0, dn, bf, bl, cn);
    checks++;
    if (dc !== 35 || bf !== 1) begin
      failures++; $display("[TB] FAIL zero_mult_timing: got done@%0d busy@%0d expected 35/1", dc, bf);
    end
`endif
    checks++;
    if (Hi !== 32'd0 || Lo !== 32'd0) begin
      failures++; $display("[TB] FAIL zero_mult_result: got %h_%h expected 0_0", Hi, Lo);
    end
  endtask

  task automatic test_reset_mid();
    Start = 1'b1; Op = 1'b0; RegA = 32'd11; RegB = 32'd13;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    checks++;
    if (Unit_Step !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid_running: got %b expected 1", Unit_Step); end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Div0, Unit_Clr, Unit_Op, Unit_Step} !== 6'b0 || {Hi, Lo, Unit_A, Unit_B} !== 128'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_async: got ctrl=%b data=%h expected 0", {Busy, Done, Div0, Unit_Clr, Unit_Op, Unit_Step}, {Hi, Lo, Unit_A, Unit_B});
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_abort();
    test_hi_write();
    test_back_to_back();
    test_early_out();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
